softermax: RTL and testbench

- Streaming base-2 softmax ("softermax") over one row of ROW_WIDTH signed fixed-point scores.
- Accumulates an online running integer max and a renormalised denominator while inputs arrive.
- Then divides each stored exponential by the denominator and holds the probabilities in an internal buffer, read randomly via read_addr.
- Sits in the vector engine after the attention-score datapath.

---
 rtl/softermax_pkg.sv | 36 +++
 rtl/softermax_div.sv | 72 +++++++
 rtl/softermax.sv | 165 ++++++++++++++++
 tb/tb_softermax.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/softermax_pkg.sv
// Shared types and fixed-point helpers for the streaming base-2 softmax.
package softermax_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_NORM  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam int EXP_FRAC      = 16;
  localparam int DEF_ROW_WIDTH = 8;

  // 2^(ipart + frac) for ipart <= 0, frac left-aligned; result is unsigned Q1.EXP_FRAC.
  function automatic logic [EXP_FRAC:0] pow2(input logic signed [31:0] ipart,
                                             input logic [EXP_FRAC-1:0] frac);
    if (ipart < -32'sd16) begin
      return '0;
    end else if (ipart > 32'sd0) begin
      return {1'b1, frac};
    end else begin
      return {1'b1, frac} >> (-ipart);
    end
  endfunction

  function automatic logic signed [31:0] ceil_int(input logic signed [31:0] x, input int fb);
    logic [31:0] mask;
    mask = (32'd1 << fb) - 32'd1;
    if (($unsigned(x) & mask) != 32'd0) begin
      return (x >>> fb) + 32'sd1;
    end else begin
      return x >>> fb;
    end
  endfunction

endpackage

// File: rtl/softermax_div.sv
// Sequential restoring divider: one load cycle, then Q_W iterations, one quotient bit each.
module softermax_div
  import softermax_pkg::*;
#(
  parameter int NUM_W = 49,
  parameter int DEN_W = 32,
  parameter int Q_W   = 33
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [NUM_W-1:0] num_i,
  input  logic [DEN_W-1:0] den_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [Q_W-1:0]   quot_o
);

  localparam int CW = $clog2(Q_W);
  localparam logic [CW-1:0] LAST_CNT = CW'(Q_W - 1);

  logic             busy_q;
  logic             done_q;
  logic [CW-1:0]    cnt_q;
  logic [DEN_W-1:0] rem_q;
  logic [DEN_W-1:0] den_q;
  logic [Q_W-1:0]   quot_q;
  logic [DEN_W:0]   shifted_s;
  logic [DEN_W:0]   trial_s;

  // Shift in the next numerator bit and trial-subtract; no borrow means the bit is 1.
  always_comb begin
    shifted_s = {rem_q, quot_q[Q_W-1]};
    trial_s   = shifted_s - {1'b0, den_q};
  end

  // The quotient register doubles as the low-numerator shift register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      den_q  <= '0;
      quot_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (busy_q) begin
        rem_q  <= trial_s[DEN_W] ? shifted_s[DEN_W-1:0] : trial_s[DEN_W-1:0];
        quot_q <= {quot_q[Q_W-2:0], ~trial_s[DEN_W]};
        if (cnt_q == LAST_CNT) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
          cnt_q  <= '0;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end else if (start_i) begin
        rem_q  <= DEN_W'(num_i[NUM_W-1:Q_W]);
        quot_q <= num_i[Q_W-1:0];
        den_q  <= den_i;
        cnt_q  <= '0;
        busy_q <= 1'b1;
      end
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign quot_o = quot_q;

endmodule

// File: rtl/softermax.sv
// Streaming base-2 softmax: online max/denominator accumulation, then per-element
// division into a randomly readable probability buffer.
module softermax
  import softermax_pkg::*;
#(
  parameter int DATA_SIZE  = 16,
  parameter int LARGE_SIZE = 32,
  parameter int ROW_WIDTH  = DEF_ROW_WIDTH,
  parameter int FRAC_BITS  = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         input_valid,
  input  logic [DATA_SIZE-1:0]         input_vector,
  input  logic [$clog2(ROW_WIDTH)-1:0] read_addr,
  output logic                         norm_valid,
  output logic                         final_out_valid,
  output logic [LARGE_SIZE:0]          prob_buffer_out
);

  localparam int AW = $clog2(ROW_WIDTH);
  localparam int MW = DATA_SIZE - FRAC_BITS + 1;
  localparam int TW = DATA_SIZE + 2;
  localparam int EW = EXP_FRAC + 1;
  localparam int NW = EW + LARGE_SIZE;
  localparam logic [AW-1:0] LAST_IDX = AW'(ROW_WIDTH - 1);

  function automatic logic signed [MW-1:0] ceil_m(input logic signed [DATA_SIZE-1:0] x);
    return MW'(ceil_int(32'(x), FRAC_BITS));
  endfunction

  function automatic logic [EW-1:0] exp_of(input logic signed [DATA_SIZE-1:0] x,
                                           input logic signed [MW-1:0] m);
    logic signed [TW-1:0] t;
    logic signed [TW-1:0] ip;
    logic [EXP_FRAC-1:0]  fr;
    t  = TW'(x) - (TW'(m) <<< FRAC_BITS);
    ip = t >>> FRAC_BITS;
    fr = '0;
    fr[EXP_FRAC-1 -: FRAC_BITS] = t[FRAC_BITS-1:0];
    return pow2(32'(ip), fr);
  endfunction

  state_e                  state_q;
  logic [AW-1:0]           cnt_q;
  logic signed [MW-1:0]    m_q;
  logic [LARGE_SIZE-1:0]   d_q;
  logic [DATA_SIZE-1:0]    x_buf_q [ROW_WIDTH];
  logic [LARGE_SIZE:0]     prob_q  [ROW_WIDTH];
  logic                    norm_valid_q;
  logic                    final_q;
  logic                    first_q;
  logic [AW-1:0]           rd_idx_q;
  logic [AW-1:0]           wr_idx_q;

  logic                    accept_s;
  logic                    elem0_s;
  logic [AW-1:0]           slot_s;
  logic signed [MW-1:0]    ceil_x_s;
  logic signed [MW-1:0]    m_new_d;
  logic signed [MW:0]      shift_s;
  logic [EW-1:0]           e_in_s;
  logic [LARGE_SIZE-1:0]   d_new_d;
  logic [EW-1:0]           e_norm_s;
  logic                    div_start_s;
  logic                    div_busy_s;
  logic                    div_done_s;
  logic [LARGE_SIZE:0]     div_quot_s;

  // Running-max update and renormalised denominator for the element on the input.
  always_comb begin
    accept_s = input_valid && (state_q != S_NORM);
    elem0_s  = (state_q == S_IDLE) || (state_q == S_DONE);
    slot_s   = elem0_s ? '0 : cnt_q;
    ceil_x_s = ceil_m(input_vector);
    m_new_d  = (elem0_s || (ceil_x_s > m_q)) ? ceil_x_s : m_q;
    shift_s  = (MW+1)'(m_new_d) - (MW+1)'(m_q);
    e_in_s   = exp_of(input_vector, m_new_d);
    if (elem0_s) begin
      d_new_d = LARGE_SIZE'(e_in_s);
    end else if (shift_s >= (MW+1)'(LARGE_SIZE)) begin
      d_new_d = LARGE_SIZE'(e_in_s);
    end else begin
      d_new_d = (d_q >> shift_s) + LARGE_SIZE'(e_in_s);
    end
    e_norm_s    = exp_of(x_buf_q[rd_idx_q], m_q);
    div_start_s = (state_q == S_NORM) && !div_busy_s &&
                  (first_q || (div_done_s && (wr_idx_q != LAST_IDX)));
  end

  softermax_div #(
    .NUM_W (NW),
    .DEN_W (LARGE_SIZE),
    .Q_W   (LARGE_SIZE + 1)
  ) u_div (
    .clk_i   (clk),
    .rst_i   (rst_n),
    .start_i (div_start_s),
    .num_i   ({e_norm_s, {LARGE_SIZE{1'b0}}}),
    .den_i   (d_q),
    .busy_o  (div_busy_s),
    .done_o  (div_done_s),
    .quot_o  (div_quot_s)
  );

  // Row FSM: accumulate, then feed the divider one element at a time and collect quotients.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      m_q          <= '0;
      d_q          <= '0;
      norm_valid_q <= 1'b0;
      final_q      <= 1'b0;
      first_q      <= 1'b0;
      rd_idx_q     <= '0;
      wr_idx_q     <= '0;
      for (int i = 0; i < ROW_WIDTH; i++) begin
        x_buf_q[i] <= '0;
        prob_q[i]  <= '0;
      end
    end else begin
      final_q <= 1'b0;
      case (state_q)
        S_IDLE, S_ACCUM, S_DONE: begin
          if (accept_s) begin
            x_buf_q[slot_s] <= input_vector;
            m_q             <= m_new_d;
            d_q             <= d_new_d;
            norm_valid_q    <= 1'b0;
            cnt_q           <= slot_s + AW'(1);
            if (slot_s == LAST_IDX) begin
              state_q  <= S_NORM;
              first_q  <= 1'b1;
              rd_idx_q <= '0;
            end else begin
              state_q <= S_ACCUM;
            end
          end
        end
        S_NORM: begin
          if (div_start_s) begin
            rd_idx_q <= rd_idx_q + AW'(1);
            wr_idx_q <= rd_idx_q;
            first_q  <= 1'b0;
          end
          if (div_done_s) begin
            prob_q[wr_idx_q] <= div_quot_s;
            if (wr_idx_q == LAST_IDX) begin
              state_q      <= S_DONE;
              norm_valid_q <= 1'b1;
              final_q      <= 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign norm_valid      = norm_valid_q;
  assign final_out_valid = final_q;
  assign prob_buffer_out = prob_q[read_addr];

endmodule

// File: tb/tb_softermax.sv
// Directed bench for softermax: table of rows with hand-computed probabilities plus reset/stream sequences.
module tb_softermax;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        input_valid = 1'b0;
  logic [15:0] input_vector = 16'h0000;
  logic [2:0]  read_addr = 3'd0;
  logic        norm_valid;
  logic        final_out_valid;
  logic [32:0] prob_buffer_out;

  always #5 clk = ~clk;

  softermax dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .input_valid     (input_valid),
    .input_vector    (input_vector),
    .read_addr       (read_addr),
    .norm_valid      (norm_valid),
    .final_out_valid (final_out_valid),
    .prob_buffer_out (prob_buffer_out)
  );

  typedef struct packed {
    logic [7:0][15:0] x;
    logic [7:0][32:0] p;
  } vec_t;

  vec_t vecs[6];
  int   tests = 0;
  int   fails = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_row(input vec_t v, input bit gaps);
    for (int i = 0; i < 8; i++) begin
      input_valid  = 1'b1;
      input_vector = v.x[i];
      tick();
      if (i == 0) check("norm_valid_clear", 64'(norm_valid), 64'd0);
      if (gaps && i < 7) begin
        input_valid  = 1'b0;
        input_vector = 16'h2000;
        tick();
        tick();
      end
    end
    input_valid = 1'b0;
  endtask

  task automatic wait_done(input int exp_lat);
    int n;
    n = 0;
    while (!final_out_valid && n < 1000) begin
      tick();
      n++;
    end
    check("latency", 64'(n), 64'(exp_lat));
    tick();
    check("pulse_width", 64'(final_out_valid), 64'd0);
    check("norm_valid", 64'(norm_valid), 64'd1);
  endtask

  task automatic check_probs(input vec_t v);
    for (int a = 0; a < 8; a++) begin
      read_addr = 3'(a);
      #1;
      check($sformatf("prob[%0d]", a), 64'(prob_buffer_out), 64'(v.p[a]));
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      vecs[0].x[i] = 16'h0100; vecs[0].p[i] = 33'h0_2000_0000;
      vecs[1].x[i] = (i == 0) ? 16'h0100 : 16'h0000;
      vecs[1].p[i] = (i == 0) ? 33'h0_38E3_8E38 : 33'h0_1C71_C71C;
      vecs[2].x[i] = (i == 0) ? 16'h2000 : 16'h0000;
      vecs[2].p[i] = (i == 0) ? 33'h1_0000_0000 : 33'h0_0000_0000;
      vecs[3].x[i] = 16'h0080; vecs[3].p[i] = 33'h0_2000_0000;
      vecs[4].x[i] = 16'hFF80; vecs[4].p[i] = 33'h0_2000_0000;
      vecs[5].x[i] = (i == 7) ? 16'h0100 : 16'h0000;
      vecs[5].p[i] = (i == 7) ? 33'h0_38E3_8E38 : 33'h0_1C71_C71C;
    end

    #1 rst_n = 1'b1;
    tick(); tick();
    check("rst_norm_valid", 64'(norm_valid), 64'd0);
    check("rst_final", 64'(final_out_valid), 64'd0);
    check("rst_prob", 64'(prob_buffer_out), 64'd0);
    rst_n = 1'b0;
    tick();

    for (int r = 0; r < 6; r++) begin
      send_row(vecs[r], r[0]);
      wait_done(273);
      check_probs(vecs[r]);
    end

    // Reset in the middle of a row discards the partial row and the old buffer.
    for (int i = 0; i < 3; i++) begin
      input_valid  = 1'b1;
      input_vector = 16'h2000;
      tick();
    end
    input_valid = 1'b0;
    rst_n = 1'b1;
    read_addr = 3'd0;
    tick();
    check("midrow_rst_norm_valid", 64'(norm_valid), 64'd0);
    check("midrow_rst_final", 64'(final_out_valid), 64'd0);
    check("midrow_rst_prob", 64'(prob_buffer_out), 64'd0);
    rst_n = 1'b0;
    tick();
    send_row(vecs[0], 1'b0);
    wait_done(273);
    check_probs(vecs[0]);

    // Continuous valid for 20 cycles: inputs past the eighth land in NORM and are ignored.
    for (int i = 0; i < 20; i++) begin
      input_valid  = 1'b1;
      input_vector = (i < 8) ? vecs[1].x[i] : 16'h2000;
      tick();
    end
    input_valid = 1'b0;
    wait_done(261);
    check_probs(vecs[1]);
    tick(); tick();
    check("done_hold", 64'(norm_valid), 64'd1);
    send_row(vecs[5], 1'b1);
    wait_done(273);
    check_probs(vecs[5]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
